// File: rtl/lamp_seq_pkg.sv
// Shared constants for the BCD lamp sequencer: phase codes, segment font and
// the elaboration-time binary-to-BCD helper.
package lamp_seq_pkg;

  localparam logic [1:0] PH_RED   = 2'b00;
  localparam logic [1:0] PH_GREEN = 2'b01;
  localparam logic [1:0] PH_YEL   = 2'b10;

  typedef enum logic [1:0] {
    ST_RED   = PH_RED,
    ST_GREEN = PH_GREEN,
    ST_YEL   = PH_YEL
  } state_e;

  // Active-high patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam int MAX_DIG = 4;

  function automatic logic [4*MAX_DIG-1:0] bin2bcd(input int value, input int ndig);
    logic [4*MAX_DIG-1:0] r;
    int v;
    r = '0;
    v = value;
    for (int i = 0; i < MAX_DIG; i++) begin
      if (i < ndig) r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_dec.sv
// One BCD digit to seven segments, with blanking and selectable polarity.
module seg7_dec
  import lamp_seq_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  input  logic       active_low,
  output logic [6:0] seg
);

  logic [6:0] pat;

  always_comb begin
    pat = SEG_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0:    pat = SEG_0;
        4'd1:    pat = SEG_1;
        4'd2:    pat = SEG_2;
        4'd3:    pat = SEG_3;
        4'd4:    pat = SEG_4;
        4'd5:    pat = SEG_5;
        4'd6:    pat = SEG_6;
        4'd7:    pat = SEG_7;
        4'd8:    pat = SEG_8;
        4'd9:    pat = SEG_9;
        default: pat = SEG_BLANK;
      endcase
    end
  end

  assign seg = active_low ? ~pat : pat;

endmodule

// File: rtl/lamp_seq_bcd.sv
// Three-phase lamp sequencer (RED->GREEN->YELLOW) with a prescaled BCD
// countdown shown on NDIG seven-segment digits.
module lamp_seq_bcd
  import lamp_seq_pkg::*;
#(
  parameter int CLK_DIV        = 4,
  parameter int RED_TIME       = 15,
  parameter int GREEN_TIME     = 12,
  parameter int YEL_TIME       = 3,
  parameter int NDIG           = 2,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              force_red,
  output logic              LED_RED,
  output logic              LED_YEL,
  output logic              LED_GREEN,
  output logic [7*NDIG-1:0] SS,
  output logic [1:0]        phase
);

  localparam int PW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CW   = 4 * NDIG;
  localparam int TMAX = 10 ** NDIG - 1;

  localparam logic [CW-1:0] RED_BCD   = CW'(bin2bcd(RED_TIME, NDIG));
  localparam logic [CW-1:0] GREEN_BCD = CW'(bin2bcd(GREEN_TIME, NDIG));
  localparam logic [CW-1:0] YEL_BCD   = CW'(bin2bcd(YEL_TIME, NDIG));
  localparam logic [CW-1:0] ONE_BCD   = CW'(1);
  localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_DIV - 1);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("lamp_seq_bcd: CLK_DIV must be >= 1");
  end
  if (NDIG < 1 || NDIG > MAX_DIG) begin : g_bad_ndig
    $error("lamp_seq_bcd: NDIG must be 1..4");
  end
  if (RED_TIME < 1 || RED_TIME > TMAX) begin : g_bad_red
    $error("lamp_seq_bcd: RED_TIME out of range");
  end
  if (GREEN_TIME < 1 || GREEN_TIME > TMAX) begin : g_bad_green
    $error("lamp_seq_bcd: GREEN_TIME out of range");
  end
  if (YEL_TIME < 1 || YEL_TIME > TMAX) begin : g_bad_yel
    $error("lamp_seq_bcd: YEL_TIME out of range");
  end

  state_e                st, st_nxt;
  logic [NDIG-1:0][3:0]  cnt, cnt_nxt, cnt_dec;
  logic [PW-1:0]         pre, pre_nxt;
  logic                  tick, at_one, borrow, hi_zero;
  logic [NDIG-1:0]       blank;

  assign tick   = en && (pre == PRE_LAST);
  assign at_one = (cnt == ONE_BCD);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st  <= ST_RED;
      cnt <= RED_BCD;
      pre <= '0;
    end else begin
      st  <= st_nxt;
      cnt <= cnt_nxt;
      pre <= pre_nxt;
    end
  end

  // Ripple-borrow decrement; only used when count > 1, so it never underflows
  always_comb begin
    borrow  = 1'b1;
    cnt_dec = cnt;
    for (int i = 0; i < NDIG; i++) begin
      if (borrow) begin
        if (cnt[i] == 4'd0) begin
          cnt_dec[i] = 4'd9;
        end else begin
          cnt_dec[i] = cnt[i] - 4'd1;
          borrow     = 1'b0;
        end
      end
    end
  end

  always_comb begin
    st_nxt  = st;
    cnt_nxt = cnt;
    pre_nxt = pre;
    if (en) pre_nxt = tick ? '0 : pre + PW'(1);
    if (tick) begin
      if (at_one) begin
        case (st)
          ST_RED:   begin st_nxt = ST_GREEN; cnt_nxt = GREEN_BCD; end
          ST_GREEN: begin st_nxt = ST_YEL;   cnt_nxt = YEL_BCD;   end
          default:  begin st_nxt = ST_RED;   cnt_nxt = RED_BCD;   end
        endcase
      end else begin
        cnt_nxt = cnt_dec;
      end
    end
    // Early end of GREEN wins over any tick and restarts the tick phase
    if (force_red && st == ST_GREEN) begin
      st_nxt  = ST_YEL;
      cnt_nxt = YEL_BCD;
      pre_nxt = '0;
    end
  end

  // Leading-zero blanking, scanned from the most significant digit down
  always_comb begin
    hi_zero = 1'b1;
    blank   = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      hi_zero = hi_zero && (cnt[i] == 4'd0);
      if (i > 0) blank[i] = hi_zero;
    end
  end

  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    seg7_dec u_dec (
      .bcd        (cnt[i]),
      .blank      (blank[i]),
      .active_low (SEG_ACTIVE_LOW != 0),
      .seg        (SS[7*i +: 7])
    );
  end

  assign LED_RED   = (st == ST_RED);
  assign LED_GREEN = (st == ST_GREEN);
  assign LED_YEL   = (st == ST_YEL);
  assign phase     = st;

endmodule

// File: tb/tb_lamp_seq_bcd.sv
// Bench for lamp_seq_bcd: directed scenarios plus random en/force_red traffic,
// checked every cycle against an integer countdown model.
module tb_lamp_seq_bcd;

  localparam int CLK_DIV = 4;
  localparam int NDIG    = 2;
  localparam logic [13:0] SS_15 = {7'b1111001, 7'b0010010};
  localparam logic [13:0] SS_12 = {7'b1111001, 7'b0100100};
  localparam logic [13:0] SS_3  = {7'b1111111, 7'b0110000};
  localparam logic [13:0] SS_9  = {7'b1111111, 7'b0010000};

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        en = 1'b0;
  logic        force_red = 1'b0;
  logic        LED_RED, LED_YEL, LED_GREEN;
  logic [13:0] SS;
  logic [1:0]  phase;

  int vectors = 0;
  int miscompares = 0;

  int m_ph, m_rem, m_pre;
  int dur [3] = '{15, 12, 3};
  logic [6:0] font [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  always #5 clk = ~clk;

  lamp_seq_bcd #(
    .CLK_DIV(CLK_DIV), .RED_TIME(15), .GREEN_TIME(12), .YEL_TIME(3),
    .NDIG(NDIG), .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rstn(rstn), .en(en), .force_red(force_red),
    .LED_RED(LED_RED), .LED_YEL(LED_YEL), .LED_GREEN(LED_GREEN),
    .SS(SS), .phase(phase)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [13:0] exp_ss(input int v);
    logic [13:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < NDIG; i++) begin
      if (i > 0 && v < p) r[7*i +: 7] = ~7'h00;
      else                r[7*i +: 7] = ~font[(v / p) % 10];
      p = p * 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_rem = dur[0]; m_pre = 0;
  endtask

  task automatic check_all();
    logic [2:0] exp_led;
    exp_led = (m_ph == 0) ? 3'b100 : (m_ph == 1) ? 3'b001 : 3'b010;
    chk("phase", 32'(phase), 32'(m_ph));
    chk("leds", 32'({LED_RED, LED_YEL, LED_GREEN}), 32'(exp_led));
    chk("ss", 32'(SS), 32'(exp_ss(m_rem)));
  endtask

  // One clock: drive inputs, advance the model with the same inputs, compare
  task automatic cyc(input bit e, input bit f);
    int  old_ph;
    bit  tk;
    en = e;
    force_red = f;
    @(posedge clk);
    old_ph = m_ph;
    tk = e && (m_pre == CLK_DIV - 1);
    if (e) m_pre = (m_pre + 1) % CLK_DIV;
    if (tk) begin
      if (m_rem > 1) m_rem--;
      else begin
        m_ph  = (m_ph + 1) % 3;
        m_rem = dur[m_ph];
      end
    end
    if (f && old_ph == 1) begin
      m_ph = 2; m_rem = dur[2]; m_pre = 0;
    end
    #1;
    check_all();
  endtask

  initial begin
    int  n;
    bit  seen9;

    // Reset, checked before the first clock edge
    #1 rstn = 1'b0;
    #1 model_reset();
    check_all();
    chk("rst_ss", 32'(SS), 32'(SS_15));
    #1 rstn = 1'b1;

    // Full cycle timing
    n = 0;
    do begin cyc(1, 0); n++; end while (phase == 2'b00 && n < 300);
    chk("red_len", n, 60);
    chk("green_ss", 32'(SS), 32'(SS_12));
    n = 0;
    do begin cyc(1, 0); n++; end while (phase == 2'b01 && n < 300);
    chk("green_len", n, 48);
    chk("yel_ss", 32'(SS), 32'(SS_3));
    n = 0;
    do begin cyc(1, 0); n++; end while (phase == 2'b10 && n < 300);
    chk("yel_len", n, 12);
    chk("red_ss", 32'(SS), 32'(SS_15));

    // Pause for 20 cycles mid-RED; also catch the 10 -> " 9" borrow
    n = 0;
    seen9 = 1'b0;
    do begin
      cyc(!(n >= 10 && n < 30), 0);
      n++;
      if (!seen9 && m_rem == 9 && m_ph == 0) begin
        seen9 = 1'b1;
        chk("borrow_9", 32'(SS), 32'(SS_9));
      end
    end while (phase == 2'b00 && n < 300);
    chk("pause_red_len", n, 80);
    chk("borrow_seen", 32'(seen9), 1);

    // force_red in GREEN at 7
    n = 0;
    while (m_rem != 7 && n < 300) begin cyc(1, 0); n++; end
    chk("reach_7", 32'(m_rem), 7);
    cyc(1, 1);
    chk("force_phase", 32'(phase), 2);
    chk("force_ss", 32'(SS), 32'(SS_3));
    n = 0;
    do begin cyc(1, 0); n++; end while (phase == 2'b10 && n < 300);
    chk("force_yel_len", n, 12);

    // force_red in RED does nothing
    repeat (3) begin
      cyc(1, 1);
      chk("force_in_red", 32'(phase), 0);
    end

    // Async reset mid-YELLOW, between edges
    n = 0;
    while (phase != 2'b10 && n < 300) begin cyc(1, 0); n++; end
    cyc(1, 0);
    cyc(1, 0);
    #2 rstn = 1'b0;
    #1 model_reset();
    check_all();
    chk("mid_rst_ss", 32'(SS), 32'(SS_15));
    #2 rstn = 1'b1;
    n = 0;
    do begin cyc(1, 0); n++; end while (SS == SS_15 && n < 20);
    chk("first_tick", n, 4);

    // Random traffic
    repeat (3000) begin
      cyc($urandom_range(0, 7) != 0,
          (m_ph == 1) ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 9) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lamp_seq_bcd.md
Name: lamp_seq_bcd

Overview:
- Parametrised successor to the two-lamp square-wave block: a three-phase lamp sequencer (RED → GREEN → YELLOW → RED).
- Each phase counts down a per-phase duration in BCD and drives the remaining time onto NDIG seven-segment digits.
- A clock prescaler sets the tick rate. Adds a run/pause enable and a force-to-red request that the old block lacks.
- Sits at board top level, directly driving LEDs and seven-segment pins.

Parameters:
- CLK_DIV, 4: clk cycles per countdown tick; ≥1.
- RED_TIME, 15: RED phase length in ticks; 1..10^NDIG-1.
- GREEN_TIME, 12: GREEN phase length in ticks; same range.
- YEL_TIME, 3: YELLOW phase length in ticks; same range.
- NDIG, 2: number of BCD digits displayed; 1..4.
- SEG_ACTIVE_LOW, 1: 1 = segment on drives 0.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- en  in  1  1 = run; 0 = freeze prescaler and countdown.
- force_red  in  1  request early end of GREEN.
- LED_RED  out  1  high in RED.
- LED_YEL  out  1  high in YELLOW.
- LED_GREEN  out  1  high in GREEN.
- SS  out  7*NDIG  digit i at SS[7i+6:7i]; digit 0 = units; bit order {g,f,e,d,c,b,a}, a = bit 0.
- phase  out  2  00 RED, 01 GREEN, 10 YELLOW.

Behaviour:
- Reset (async, rstn=0):
  - state=RED, BCD count = RED_TIME, prescaler = 0.
  - LED_RED=1, LED_YEL=0, LED_GREEN=0, phase=00.
  - SS shows RED_TIME immediately, with no clock edge needed.
- Prescaler:
  - Width $clog2(CLK_DIV) (1 bit minimum).
  - Increments when en=1; wraps CLK_DIV-1 → 0.
  - tick=1 on the cycle prescaler==CLK_DIV-1 and en=1.
  - CLK_DIV=1 gives tick every enabled cycle.
- Countdown:
  - NDIG BCD digit registers.
  - On tick with count>1: decrement with borrow chain (units 0 → 9, borrow into next digit).
  - On tick with count==1: advance state and load the next phase time.
  - Each phase therefore lasts exactly T*CLK_DIV enabled cycles. Displayed values run T..1; 0 is never displayed.
- Transitions: RED → GREEN (load GREEN_TIME), GREEN → YELLOW (load YEL_TIME), YELLOW → RED (load RED_TIME).
- force_red, sampled each clk edge:
  - In GREEN: next state YELLOW, count = YEL_TIME, prescaler cleared to 0.
  - Ignored in RED and YELLOW.
  - Acts regardless of en.
  - Coincident with the GREEN terminal tick: same result (YELLOW, YEL_TIME, prescaler 0).
- en=0: prescaler, count and state hold; outputs stable.
- Parameter→BCD conversion is done at elaboration by a constant function. Out-of-range times are an elaboration error ($error / generate-time check).
- Output timing: LEDs and phase decode from the state register; SS decodes from the BCD registers. Combinational from registers, no added latency, glitch-free relative to clk.
- Leading-zero blanking: digit i>0 is blank when it and all higher digits are 0. Digit 0 is never blanked.
- Decoder: codes 10..15 give blank (unreachable; defensive only).
- Polarity: SEG_ACTIVE_LOW inverts all segment bits, including the blank pattern.
- Reset asserted mid-phase: immediate return to the reset values above; the prescaler restarts from 0 after release.

Decomposition:
- Package lamp_seq_pkg:
  - phase encoding constants (RED/GREEN/YELLOW).
  - seven-segment active-high pattern constants for 0-9 and blank.
  - constant function bin2bcd(value, ndig).
- Sub-module seg7_dec:
  - 4-bit BCD + blank + active_low → 7-bit segments.
  - Instantiated NDIG times via generate.

Test Plan:
- All scenarios use defaults (CLK_DIV=4, NDIG=2, active-low).
1. Reset: rstn=0 → LED_RED=1, LED_YEL=0, LED_GREEN=0, phase=00, SS[6:0]=7'b0010010 ("5"), SS[13:7]=7'b1111001 ("1"), all before any clk edge.
2. Full cycle, en=1: GREEN after exactly 60 cycles, showing "12"; YELLOW after 48 more, showing " 3" (SS[13:7]=7'b1111111); RED "15" after 12 more; period 120 cycles.
3. Borrow/blank: RED count 10 → next tick shows " 9" (SS[6:0]=7'b0010000, SS[13:7]=7'b1111111).
4. Pause: en=0 for 20 cycles mid-RED → SS and prescaler frozen; RED→GREEN occurs exactly 20 cycles later than in scenario 2.
5. force_red pulse during GREEN at "07" → next edge: phase=10, SS " 3", prescaler=0; YELLOW lasts 12 cycles. Same pulse in RED → no change.
6. Async reset mid-YELLOW between clk edges → outputs become RED/"15" before the next edge. After release, first tick comes 4 cycles later.
